acc_slot_sched: RTL and testbench

Slot scheduler for the fixed-point shift/accumulate datapath. It owns the accumulator slot pool (one slot per `input_acc_cs` value). The block:
- allocates a free slot to each incoming reduction job and clears that slot;
- gates terms into the shifter and tags each one with its slot select;
- counts completed accumulates per slot, and on reaching the job's term count hands the slot to the result drain;
- frees the slot once the drain has been accepted.

It sits between the job/term sources and the shift-accumulate unit.

---
 rtl/acc_slot_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_acc_slot_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_slot_sched.sv
// Accumulator slot scheduler: allocates, clears, grants, tracks and drains accumulator slots.
// Optional statistics counters are enabled with the ACC_SLOT_SCHED_STATS_EN macro.
module acc_slot_sched #(
  parameter int NUM_SLOTS  = 32,
  parameter int SLOT_W     = $clog2(NUM_SLOTS),
  parameter int LEN_W      = 16,
  parameter int INFL_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LEN_W-1:0]  req_len,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [SLOT_W-1:0] grant_slot,
  output logic              clr_valid,
  input  logic              clr_ready,
  output logic [7:0]        clr_cs,
  input  logic              term_valid,
  output logic              term_ready,
  input  logic [SLOT_W-1:0] term_slot,
  output logic              shift_valid,
  input  logic              shift_ready,
  output logic [7:0]        acc_cs,
  input  logic              add_valid,
  output logic              drain_valid,
  input  logic              drain_ready,
  output logic [SLOT_W-1:0] drain_slot,
  output logic              err
`ifdef ACC_SLOT_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_jobs,
  output logic [31:0]       stat_stall
`endif
);

  // Every handshake transfers on a cycle where valid and ready are both high;
  // a valid source holds its payload stable until that cycle.
  localparam int PTR_W = $clog2(INFL_DEPTH);

  typedef enum logic [1:0] {A_IDLE, A_CLEAR, A_GRANT} alloc_state_e;
  typedef enum logic [1:0] {S_FREE, S_ACTIVE, S_DONE} slot_state_e;

  alloc_state_e      fsm, fsm_n;
  logic [SLOT_W-1:0] cur_slot;
  logic              alloc, clr_done;

  slot_state_e       st   [NUM_SLOTS];
  slot_state_e       st_n [NUM_SLOTS];
  logic [LEN_W-1:0]  rem  [NUM_SLOTS];
  logic [LEN_W-1:0]  rem_n[NUM_SLOTS];

  logic              any_free, done_any_n;
  logic [SLOT_W-1:0] free_idx, done_idx_n;

  logic [SLOT_W-1:0] fifo_mem [INFL_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    infl_cnt;
  logic              infl_full, infl_empty, push, pop;
  logic [SLOT_W-1:0] head;

  logic              drain_valid_q, drain_fire;
  logic [SLOT_W-1:0] drain_slot_q;
  logic              err_q, err_n;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (st[i] == S_FREE) begin
        any_free = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    fsm_n       = fsm;
    req_ready   = 1'b0;
    clr_valid   = 1'b0;
    grant_valid = 1'b0;
    alloc       = 1'b0;
    clr_done    = 1'b0;
    case (fsm)
      A_IDLE: begin
        req_ready = any_free;
        if (req_valid && any_free) begin
          alloc = 1'b1;
          fsm_n = A_CLEAR;
        end
      end
      A_CLEAR: begin
        clr_valid = 1'b1;
        if (clr_ready) begin
          clr_done = 1'b1;
          fsm_n    = A_GRANT;
        end
      end
      A_GRANT: begin
        grant_valid = 1'b1;
        if (grant_ready) fsm_n = A_IDLE;
      end
      default: fsm_n = A_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm      <= A_IDLE;
      cur_slot <= '0;
    end else begin
      fsm <= fsm_n;
      if (alloc) cur_slot <= free_idx;
    end
  end

  assign grant_slot = cur_slot;
  assign clr_cs     = 8'(cur_slot);

  assign infl_full   = (infl_cnt == (PTR_W + 1)'(INFL_DEPTH));
  assign infl_empty  = (infl_cnt == '0);
  assign shift_valid = term_valid & ~infl_full;
  assign term_ready  = shift_ready & ~infl_full;
  assign acc_cs      = 8'(term_slot);
  assign push        = term_valid & term_ready;
  assign pop         = add_valid & ~infl_empty;
  assign head        = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= term_slot;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      infl_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      infl_cnt <= infl_cnt + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  assign drain_fire = drain_valid_q & drain_ready;

  // Allocation only ever targets a slot that was FREE in the registered view,
  // so a slot freed by this cycle's drain is not reused until the next cycle.
  always_comb begin
    st_n  = st;
    rem_n = rem;
    err_n = err_q;
    if (drain_fire) st_n[drain_slot_q] = S_FREE;
    if (pop && st[head] == S_ACTIVE) begin
      if (rem[head] == '0) begin
        err_n = 1'b1;
      end else begin
        rem_n[head] = rem[head] - 1'b1;
        if (rem[head] == LEN_W'(1)) st_n[head] = S_DONE;
      end
    end
    if (add_valid && infl_empty) err_n = 1'b1;
    if (push && st[term_slot] != S_ACTIVE) err_n = 1'b1;
    if (clr_done && st[cur_slot] == S_ACTIVE && rem[cur_slot] == '0) st_n[cur_slot] = S_DONE;
    if (alloc) begin
      st_n[free_idx]  = S_ACTIVE;
      rem_n[free_idx] = req_len;
    end
  end

  always_comb begin
    done_any_n = 1'b0;
    done_idx_n = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (st_n[i] == S_DONE) begin
        done_any_n = 1'b1;
        done_idx_n = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st[i]  <= S_FREE;
        rem[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      st    <= st_n;
      rem   <= rem_n;
      err_q <= err_n;
    end
  end

  // The offered slot is frozen while waiting for drain_ready.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drain_valid_q <= 1'b0;
      drain_slot_q  <= '0;
    end else if (!(drain_valid_q && !drain_ready)) begin
      drain_valid_q <= done_any_n;
      if (done_any_n) drain_slot_q <= done_idx_n;
    end
  end

  assign drain_valid = drain_valid_q;
  assign drain_slot  = drain_slot_q;
  assign err         = err_q;

`ifdef ACC_SLOT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_jobs  <= '0;
      stat_stall <= '0;
    end else begin
      if (drain_fire) stat_jobs <= stat_jobs + 32'd1;
      if (term_valid && !term_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_slot_sched.sv
// Directed bench for acc_slot_sched: a cycle table for the single and zero-length
// jobs, then hand sequences for pool exhaustion, backpressure, interleave, errors, reset.
module tb_acc_slot_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_valid, req_ready;
  logic [15:0] req_len;
  logic       grant_valid, grant_ready;
  logic [4:0] grant_slot;
  logic       clr_valid, clr_ready;
  logic [7:0] clr_cs;
  logic       term_valid, term_ready;
  logic [4:0] term_slot;
  logic       shift_valid, shift_ready;
  logic [7:0] acc_cs;
  logic       add_valid;
  logic       drain_valid, drain_ready;
  logic [4:0] drain_slot;
  logic       err;
`ifdef ACC_SLOT_SCHED_STATS_EN
  logic [31:0] stat_jobs, stat_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  acc_slot_sched dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_slot(grant_slot),
    .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_cs(clr_cs),
    .term_valid(term_valid), .term_ready(term_ready), .term_slot(term_slot),
    .shift_valid(shift_valid), .shift_ready(shift_ready), .acc_cs(acc_cs),
    .add_valid(add_valid),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_slot(drain_slot),
    .err(err)
`ifdef ACC_SLOT_SCHED_STATS_EN
    , .stat_jobs(stat_jobs), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int rv, len, cr, gr, tv, ts, av, dr;
    int rr, cv, gv, gs, sv, dv, ds, er;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_len     = '0;
    clr_ready   = 1'b1;
    grant_ready = 1'b1;
    term_valid  = 1'b0;
    term_slot   = '0;
    shift_ready = 1'b1;
    add_valid   = 1'b0;
    drain_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    #1;
  endtask

  task automatic alloc_job(input int len, output int slot);
    int n;
    req_valid = 1'b1;
    req_len   = 16'(len);
    #1;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    chk("alloc req_ready", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    n = 0;
    while (!grant_valid && n < 50) begin step(); n++; end
    chk("alloc grant_valid", 32'(grant_valid), 1);
    slot = int'(grant_slot);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 1);
    chk({tag, " grant_valid"}, 32'(grant_valid), 0);
    chk({tag, " clr_valid"}, 32'(clr_valid), 0);
    chk({tag, " drain_valid"}, 32'(drain_valid), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " grant_slot"}, 32'(grant_slot), 0);
    chk({tag, " clr_cs"}, 32'(clr_cs), 0);
    chk({tag, " drain_slot"}, 32'(drain_slot), 0);
  endtask

  initial begin
    int s;
    //            rv len cr gr tv ts av dr   rr cv gv gs sv dv ds er
    vecs[0]  = '{1, 3, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0};
    vecs[10] = '{0, 0, 1, 1, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 0, 0};
    vecs[11] = '{1, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 1, 0, 0};
    vecs[14] = '{0, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0, 0};
    vecs[15] = '{0, 0, 1, 1, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 0, 0};
    vecs[16] = '{0, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};

    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    #1;
    check_reset_values("reset");

    // single job (len 3) followed by a zero-length job reusing slot 0
    for (int i = 0; i < NV; i++) begin
      req_valid   = 1'(vecs[i].rv);
      req_len     = 16'(vecs[i].len);
      clr_ready   = 1'(vecs[i].cr);
      grant_ready = 1'(vecs[i].gr);
      term_valid  = 1'(vecs[i].tv);
      term_slot   = 5'(vecs[i].ts);
      add_valid   = 1'(vecs[i].av);
      drain_ready = 1'(vecs[i].dr);
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), vecs[i].rr);
      chk($sformatf("v%0d clr_valid", i), 32'(clr_valid), vecs[i].cv);
      chk($sformatf("v%0d grant_valid", i), 32'(grant_valid), vecs[i].gv);
      chk($sformatf("v%0d grant_slot", i), 32'(grant_slot), vecs[i].gs);
      chk($sformatf("v%0d shift_valid", i), 32'(shift_valid), vecs[i].sv);
      chk($sformatf("v%0d drain_valid", i), 32'(drain_valid), vecs[i].dv);
      chk($sformatf("v%0d drain_slot", i), 32'(drain_slot), vecs[i].ds);
      chk($sformatf("v%0d err", i), 32'(err), vecs[i].er);
      step();
    end
    idle_inputs();
    #1;

    // pool exhaustion
    for (int i = 0; i < 32; i++) begin
      alloc_job(1, s);
      chk($sformatf("pool slot %0d", i), 32'(s), 32'(i));
    end
    chk("pool full req_ready", 32'(req_ready), 0);
    chk("pool full drain_valid", 32'(drain_valid), 0);
    term_valid = 1'b1;
    term_slot  = 5'd5;
    #1;
    chk("pool term_ready", 32'(term_ready), 1);
    chk("pool acc_cs", 32'(acc_cs), 5);
    step();
    term_valid = 1'b0;
    add_valid  = 1'b1;
    step();
    add_valid = 1'b0;
    #1;
    chk("pool drain_valid", 32'(drain_valid), 1);
    chk("pool drain_slot", 32'(drain_slot), 5);
    drain_ready = 1'b1;
    step();
    drain_ready = 1'b0;
    alloc_job(1, s);
    chk("pool regrant slot", 32'(s), 5);

    // in-flight backpressure
    for (int i = 0; i < 16; i++) begin
      term_valid = 1'b1;
      term_slot  = 5'(i);
      #1;
      chk($sformatf("bp term_ready %0d", i), 32'(term_ready), 1);
      step();
    end
    term_slot = 5'd16;
    #1;
    chk("bp full term_ready", 32'(term_ready), 0);
    chk("bp full shift_valid", 32'(shift_valid), 0);
    add_valid = 1'b1;
    #1;
    chk("bp pop same cycle term_ready", 32'(term_ready), 0);
    step();
    add_valid = 1'b0;
    #1;
    chk("bp after pop term_ready", 32'(term_ready), 1);
    step();
    term_valid = 1'b0;
    #1;
    chk("bp err", 32'(err), 0);

    // interleaved slots 1 and 2
    do_reset();
    alloc_job(5, s);
    chk("il slot0", 32'(s), 0);
    alloc_job(2, s);
    chk("il slot1", 32'(s), 1);
    alloc_job(2, s);
    chk("il slot2", 32'(s), 2);
    for (int i = 0; i < 4; i++) begin
      term_valid = 1'b1;
      term_slot  = (i % 2 == 0) ? 5'd1 : 5'd2;
      step();
    end
    term_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      add_valid = 1'b1;
      #1;
      if (i == 3) begin
        chk("il first done valid", 32'(drain_valid), 1);
        chk("il first done slot", 32'(drain_slot), 1);
      end
      step();
    end
    add_valid = 1'b0;
    #1;
    chk("il hold slot", 32'(drain_slot), 1);
    drain_ready = 1'b1;
    step();
    drain_ready = 1'b0;
    #1;
    chk("il second valid", 32'(drain_valid), 1);
    chk("il second slot", 32'(drain_slot), 2);
    drain_ready = 1'b1;
    step();
    drain_ready = 1'b0;
    #1;
    chk("il drained", 32'(drain_valid), 0);
    chk("il err", 32'(err), 0);

    // add_valid with an empty in-flight FIFO
    add_valid = 1'b1;
    step();
    add_valid = 1'b0;
    #1;
    chk("empty add err", 32'(err), 1);
    chk("empty add drain_valid", 32'(drain_valid), 0);

    // reset in the middle of a clear
    req_valid = 1'b1;
    req_len   = 16'd1;
    clr_ready = 1'b0;
    step();
    req_valid = 1'b0;
    #1;
    chk("mid clr_valid", 32'(clr_valid), 1);
    chk("mid clr_cs", 32'(clr_cs), 1);
    do_reset();
    check_reset_values("mid reset");

    // term to a FREE slot
    term_valid = 1'b1;
    term_slot  = 5'd3;
    step();
    term_valid = 1'b0;
    #1;
    chk("free slot term err", 32'(err), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
